// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: single-outstanding req/ack fetch port feeding a prefetch FIFO toward ID.
// Define IF_PERF_CNT_EN to add the saturating fetch_cnt / bubble_cnt performance counters.
module if_prefetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     ADDR_SHIFT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            redir_i,
    input  logic [XLEN-1:0] redir_pc_i,
    output logic            i_req,
    output logic [XLEN-1:0] i_addr,
    input  logic            i_ack,
    input  logic [31:0]     i_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_next_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_addr;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_mem_instr [DEPTH];
    logic [XLEN-1:0] r_mem_npc   [DEPTH];
    logic [31:0]     r_hold_instr;
    logic [XLEN-1:0] r_hold_npc;

    logic w_issue;
    logic w_push;
    logic w_pop;
    logic w_valid;

    assign w_valid = (r_count != '0);
    assign w_issue = (r_state == S_IDLE) && !hold_i && !redir_i && (r_count < FULL);
    assign w_push  = (r_state == S_WAIT) && i_ack && !redir_i;
    assign w_pop   = w_valid && id_ready && !redir_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next = S_WAIT;
            S_WAIT:  if (i_ack) w_next = S_IDLE;
                     else if (redir_i) w_next = S_DRAIN;
            S_DRAIN: if (i_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        i_req = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_addr <= '0;
        end else begin
            if (redir_i)     r_pc <= redir_pc_i;
            else if (w_push) r_pc <= r_pc + FOUR;
            if (w_issue) r_addr <= r_pc >> ADDR_SHIFT;
        end
    end

    // The empty-queue display value is re-registered every cycle so id_* hold after the last pop or a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_hold_instr <= '0;
            r_hold_npc   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_npc[i]   <= '0;
            end
        end else begin
            r_hold_instr <= id_instr;
            r_hold_npc   <= id_next_pc;
            if (redir_i) begin
                r_wptr  <= r_rptr;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_mem_instr[r_wptr] <= i_rdata;
                    r_mem_npc[r_wptr]   <= r_pc + FOUR;
                    r_wptr              <= r_wptr + PW'(1);
                end
                if (w_pop) r_rptr <= r_rptr + PW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            end
        end
    end

    assign i_addr     = r_addr;
    assign id_valid   = w_valid;
    assign id_instr   = w_valid ? r_mem_instr[r_rptr] : r_hold_instr;
    assign id_next_pc = w_valid ? r_mem_npc[r_rptr]   : r_hold_npc;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_push && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (id_ready && !w_valid && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: queue-based transaction model, per-cycle compare, directed and random stimulus.
// Covers the IF_PERF_CNT_EN counters when the macro is defined for the build.
module tb_if_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        hold_i;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_next_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    if_prefetch_unit #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'd0), .ADDR_SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .redir_i(redir_i), .redir_pc_i(redir_pc_i),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_next_pc(id_next_pc)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: queued {next_pc, instr} entries plus one outstanding fetch.
    logic [63:0] q[$];
    logic [63:0] m_last;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;
    int          lat;
    int          lat_fix;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a * 32'h01010101 + 32'hA5000000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last   = '0;
        m_pc     = 32'd0;
        m_addr   = '0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_fetch  = '0;
        m_bubble = '0;
        lat      = 0;
    endtask

    task automatic model_update();
        bit valid;
        int cnt0;
        bit was_out;
        valid   = (q.size() != 0);
        cnt0    = q.size();
        was_out = m_out;
        if (valid) m_last = q[0];
        if (id_ready && !valid && m_bubble != 32'hFFFFFFFF) m_bubble++;
        if (redir_i) begin
            q.delete();
            m_pc = redir_pc_i;
            if (m_out && i_ack) begin
                m_out = 1'b0;
                m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else begin
            if (valid && id_ready) void'(q.pop_front());
            if (m_out && i_ack) begin
                if (!m_stale) begin
                    q.push_back({m_pc + 32'd4, i_rdata});
                    m_pc = m_pc + 32'd4;
                    if (m_fetch != 32'hFFFFFFFF) m_fetch++;
                end
                m_out = 1'b0;
                m_stale = 1'b0;
            end else if (!was_out && !hold_i && cnt0 < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_pc >> 2;
                lat    = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic drive_mem();
        if (m_out && lat == 0) begin
            i_ack   = 1'b1;
            i_rdata = memfn(m_addr);
        end else begin
            i_ack   = 1'b0;
            i_rdata = $urandom;
            if (m_out) lat--;
        end
    endtask

    task automatic tick(input bit h, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        model_update();
        hold_i     = h;
        id_ready   = rdy;
        redir_i    = rd;
        redir_pc_i = rpc;
        drive_mem();
    endtask

    task automatic do_reset();
        #2;
        rst      = 1'b1;
        i_ack    = 1'b0;
        redir_i  = 1'b0;
        hold_i   = 1'b0;
        id_ready = 1'b0;
        #1;
        chk("rst_i_req", i_req, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_next_pc", id_next_pc, 0);
`ifdef IF_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_cnt, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("i_req", i_req, m_out);
            if (m_out) chk("i_addr", i_addr, m_addr);
            chk("id_valid", id_valid, q.size() != 0);
            chk("id_instr", id_instr, (q.size() != 0) ? q[0][31:0] : m_last[31:0]);
            chk("id_next_pc", id_next_pc, (q.size() != 0) ? q[0][63:32] : m_last[63:32]);
`ifdef IF_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, m_fetch);
            chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
        end
    end

    initial begin
        bit          prev_req;
        bit          got_rise;
        bit          hit;
        logic [31:0] rise_addr;

        rst        = 1'b1;
        hold_i     = 1'b0;
        redir_i    = 1'b0;
        redir_pc_i = '0;
        id_ready   = 1'b0;
        i_ack      = 1'b0;
        i_rdata    = '0;
        lat_fix    = 0;
        model_reset();
        do_reset();

        // Zero-wait fill with ID stalled: exactly DEPTH entries, then fetching stops.
        lat_fix = 0;
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0);
        chk("full_i_req", i_req, 0);
        chk("full_id_valid", id_valid, 1);
        chk("full_head_npc", id_next_pc, 32'd4);
        chk("full_head_instr", id_instr, 32'hA5000000);
        chk("full_model_depth", q.size(), DEPTH);
`ifdef IF_PERF_CNT_EN
        chk("full_fetch_cnt", fetch_cnt, 32'd4);
`endif
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0);
            if (i_req) break;
        end
        chk("resume_req", i_req, 1);
        chk("resume_addr", i_addr, 32'd4);
        for (int i = 0; i < 12; i++) tick(0, 1, 0, 0);

        // Redirect during a slow fetch: stale word dropped, new fetch from 0x40.
        do_reset();
        lat_fix = 3;
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 32'h40);
        tick(0, 1, 0, 0);
        prev_req = 1'b1;
        got_rise = 1'b0;
        rise_addr = '0;
        for (int i = 0; i < 30; i++) begin
            if (i_req && !prev_req && !got_rise) begin
                got_rise = 1'b1;
                rise_addr = i_addr;
            end
            prev_req = i_req;
            if (id_valid) break;
            tick(0, 0, 0, 0);
        end
        chk("redir_new_req", got_rise, 1);
        chk("redir_new_addr", rise_addr, 32'h10);
        chk("redir_first_npc", id_next_pc, 32'h44);
        chk("redir_first_instr", id_instr, 32'hB5101010);

        // Redirect coinciding with ack and pop.
        do_reset();
        lat_fix = 0;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0, 0, 0);
            if (id_valid && i_req && i_ack) begin
                redir_i    = 1'b1;
                redir_pc_i = 32'h100;
                id_ready   = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        chk("coincide_reached", hit, 1);
        tick(0, 1, 0, 0);
        chk("coincide_flushed", id_valid, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);

        // hold_i with a fetch in flight: the ack still lands, nothing new issues.
        do_reset();
        lat_fix = 2;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(1, 0, 0, 0);
        chk("hold_i_req", i_req, 0);
        chk("hold_id_valid", id_valid, 1);
        chk("hold_npc", id_next_pc, 32'd4);

        // Asynchronous reset while waiting for an ack.
        do_reset();
        lat_fix = 3;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("midwait_req_before", i_req, 1);
        do_reset();
        tick(0, 0, 0, 0);
        chk("post_rst_req", i_req, 1);
        chk("post_rst_addr", i_addr, 32'd0);
        for (int i = 0; i < 20; i++) tick(0, 1, 0, 0);

        // Randomised traffic, including redirects near the top of the address space.
        lat_fix = -1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'h0000FFFC);
            tick($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 5, rpc);
        end
        tick(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
